// File: rtl/fetch_align_queue.sv
// Halfword-granular realignment queue between fetch and decode.
// Accepts aligned 32-bit fetch words and presents one RVC or 32-bit instruction per handshake.
module fetch_align_queue #(
  parameter  int unsigned DEPTH_WORDS = 4,
  localparam int unsigned CNT_W       = $clog2(2 * DEPTH_WORDS) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             flush_half_i,
  input  logic             push_valid_i,
  input  logic [31:0]      push_data_i,
  output logic             push_ready_o,
  output logic             instr_valid_o,
  output logic [31:0]      instr_o,
  output logic             instr_compressed_o,
  input  logic             instr_ready_i,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned NUM_HW = 2 * DEPTH_WORDS;
  localparam int unsigned PTR_W  = $clog2(NUM_HW);

  logic [15:0]      hw_q [NUM_HW];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             skip_low_q, skip_low_d;

  logic [15:0]      lo, hi;
  logic             lo_is32;
  logic             valid_c, comp_c, ready_c;
  logic             push_fire, pop_fire;
  logic [CNT_W-1:0] push_amt, pop_amt;

  // Head decode straight from storage; a new word becomes visible the cycle after its push.
  always_comb begin
    lo       = hw_q[rd_ptr_q];
    hi       = hw_q[rd_ptr_q + PTR_W'(1)];
    lo_is32  = (lo[1:0] == 2'b11);
    comp_c   = (count_q != '0) && !lo_is32;
    valid_c  = comp_c || ((count_q >= CNT_W'(2)) && lo_is32);
    ready_c  = (count_q <= CNT_W'(NUM_HW - 2));
    push_fire = push_valid_i && ready_c;
    pop_fire  = valid_c && instr_ready_i;
    push_amt  = push_fire ? (skip_low_q ? CNT_W'(1) : CNT_W'(2)) : '0;
    pop_amt   = pop_fire ? (comp_c ? CNT_W'(1) : CNT_W'(2)) : '0;
  end

  // Next-state: flush wins over any concurrent push/pop.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    skip_low_d = skip_low_q;
    if (flush_i) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      skip_low_d = flush_half_i;
    end else begin
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_amt);
      wr_ptr_d = wr_ptr_q + PTR_W'(push_amt);
      count_d  = count_q + push_amt - pop_amt;
      if (push_fire) skip_low_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      skip_low_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      skip_low_q <= skip_low_d;
    end
  end

  // Storage is intentionally not reset; count gates every read.
  always_ff @(posedge clk) begin
    if (push_fire && !flush_i) begin
      if (skip_low_q) begin
        hw_q[wr_ptr_q] <= push_data_i[31:16];
      end else begin
        hw_q[wr_ptr_q]               <= push_data_i[15:0];
        hw_q[wr_ptr_q + PTR_W'(1)]   <= push_data_i[31:16];
      end
    end
  end

  always_comb begin
    push_ready_o       = ready_c;
    instr_valid_o      = valid_c;
    instr_compressed_o = comp_c;
    instr_o            = !valid_c ? 32'h0 : (comp_c ? {16'h0, lo} : {hi, lo});
    count_o            = count_q;
  end

endmodule

// File: tb/tb_fetch_align_queue.sv
// Bench for fetch_align_queue: directed vector table plus a scoreboarded random stream across wrap.
module tb_fetch_align_queue;

  logic        clk;
  logic        rst_n;
  logic        flush_i;
  logic        flush_half_i;
  logic        push_valid_i;
  logic [31:0] push_data_i;
  logic        push_ready_o;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic        instr_compressed_o;
  logic        instr_ready_i;
  logic [3:0]  count_o;

  fetch_align_queue #(.DEPTH_WORDS(4)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .flush_i            (flush_i),
    .flush_half_i       (flush_half_i),
    .push_valid_i       (push_valid_i),
    .push_data_i        (push_data_i),
    .push_ready_o       (push_ready_o),
    .instr_valid_o      (instr_valid_o),
    .instr_o            (instr_o),
    .instr_compressed_o (instr_compressed_o),
    .instr_ready_i      (instr_ready_i),
    .count_o            (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rstn;
    logic        fl;
    logic        fh;
    logic        pv;
    logic [31:0] pd;
    logic        rdy;
    logic        ev;
    logic [31:0] ei;
    logic        ec;
    logic [3:0]  ecnt;
    logic        epr;
  } vec_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        comp;
  } exp_t;

  int tests = 0;
  int fails = 0;

  vec_t        vecs[30];
  logic [15:0] src_hw[$];
  exp_t        exp_q[$];
  int          mcnt;

  function automatic vec_t mk(logic rstn, logic fl, logic fh, logic pv, logic [31:0] pd,
                              logic rdy, logic ev, logic [31:0] ei, logic ec,
                              logic [3:0] ecnt, logic epr);
    vec_t v;
    v.rstn = rstn; v.fl = fl; v.fh = fh; v.pv = pv; v.pd = pd; v.rdy = rdy;
    v.ev = ev; v.ei = ei; v.ec = ec; v.ecnt = ecnt; v.epr = epr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One scoreboard cycle: drive, compare against the model, then retire handshakes.
  task automatic step(input logic pv, input logic rdy);
    bit   ev;
    int   hl;
    logic pr_exp;
    push_valid_i  = pv && (src_hw.size() >= 2);
    push_data_i   = push_valid_i ? {src_hw[1], src_hw[0]} : 32'h0;
    instr_ready_i = rdy;
    flush_i       = 1'b0;
    flush_half_i  = 1'b0;
    #1;
    pr_exp = (mcnt <= 6);
    hl = 0;
    ev = 1'b0;
    if (exp_q.size() > 0) begin
      hl = exp_q[0].comp ? 1 : 2;
      ev = (mcnt >= hl);
    end
    chk("sb_count", 32'(count_o), 32'(mcnt));
    chk("sb_push_ready", 32'(push_ready_o), 32'(pr_exp));
    chk("sb_valid", 32'(instr_valid_o), 32'(ev));
    if (ev) begin
      chk("sb_instr", instr_o, exp_q[0].instr);
      chk("sb_comp", 32'(instr_compressed_o), 32'(exp_q[0].comp));
    end
    if (push_valid_i && pr_exp) begin
      void'(src_hw.pop_front());
      void'(src_hw.pop_front());
      mcnt += 2;
    end
    if (ev && rdy) begin
      void'(exp_q.pop_front());
      mcnt -= hl;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] h;
    logic [15:0] l;
    int          cyc;

    // Directed vectors: inputs applied this cycle, outputs expected before the edge.
    vecs[0]  = mk(1,0,0, 1,32'h0013_0093, 0,  0,32'h0,          0, 4'd0, 1);
    vecs[1]  = mk(1,0,0, 0,32'h0,         1,  1,32'h0013_0093,  0, 4'd2, 1);
    vecs[2]  = mk(1,0,0, 0,32'h0,         0,  0,32'h0,          0, 4'd0, 1);
    vecs[3]  = mk(1,0,0, 1,32'h4505_4585, 0,  0,32'h0,          0, 4'd0, 1);
    vecs[4]  = mk(1,0,0, 0,32'h0,         1,  1,32'h0000_4585,  1, 4'd2, 1);
    vecs[5]  = mk(1,0,0, 0,32'h0,         1,  1,32'h0000_4505,  1, 4'd1, 1);
    vecs[6]  = mk(1,0,0, 0,32'h0,         0,  0,32'h0,          0, 4'd0, 1);
    vecs[7]  = mk(1,0,0, 1,32'h0093_4585, 0,  0,32'h0,          0, 4'd0, 1);
    vecs[8]  = mk(1,0,0, 0,32'h0,         1,  1,32'h0000_4585,  1, 4'd2, 1);
    vecs[9]  = mk(1,0,0, 0,32'h0,         1,  0,32'h0,          0, 4'd1, 1);
    vecs[10] = mk(1,0,0, 1,32'h1111_0013, 0,  0,32'h0,          0, 4'd1, 1);
    vecs[11] = mk(1,0,0, 0,32'h0,         1,  1,32'h0013_0093,  0, 4'd3, 1);
    vecs[12] = mk(1,0,0, 0,32'h0,         1,  1,32'h0000_1111,  1, 4'd1, 1);
    vecs[13] = mk(1,0,0, 0,32'h0,         0,  0,32'h0,          0, 4'd0, 1);
    vecs[14] = mk(1,0,0, 1,32'h0013_0093, 0,  0,32'h0,          0, 4'd0, 1);
    vecs[15] = mk(1,0,0, 1,32'h0023_0113, 0,  1,32'h0013_0093,  0, 4'd2, 1);
    vecs[16] = mk(1,0,0, 1,32'h0033_0193, 0,  1,32'h0013_0093,  0, 4'd4, 1);
    vecs[17] = mk(1,1,1, 1,32'h0044_0213, 1,  1,32'h0013_0093,  0, 4'd6, 1);
    vecs[18] = mk(1,0,0, 0,32'h0,         0,  0,32'h0,          0, 4'd0, 1);
    vecs[19] = mk(1,0,0, 1,32'hABCD_0001, 0,  0,32'h0,          0, 4'd0, 1);
    vecs[20] = mk(1,0,0, 0,32'h0,         0,  1,32'h0000_ABCD,  1, 4'd1, 1);
    vecs[21] = mk(1,0,0, 0,32'h0,         1,  1,32'h0000_ABCD,  1, 4'd1, 1);
    vecs[22] = mk(1,0,0, 0,32'h0,         0,  0,32'h0,          0, 4'd0, 1);
    vecs[23] = mk(1,0,0, 1,32'h0013_0093, 0,  0,32'h0,          0, 4'd0, 1);
    vecs[24] = mk(1,0,0, 1,32'h0023_0113, 0,  1,32'h0013_0093,  0, 4'd2, 1);
    vecs[25] = mk(1,0,0, 1,32'h0033_0193, 0,  1,32'h0013_0093,  0, 4'd4, 1);
    vecs[26] = mk(1,0,0, 1,32'h0044_0213, 1,  1,32'h0013_0093,  0, 4'd6, 1);
    vecs[27] = mk(1,0,0, 0,32'h0,         0,  1,32'h0023_0113,  0, 4'd6, 1);
    vecs[28] = mk(0,0,0, 1,32'h0055_0293, 0,  1,32'h0023_0113,  0, 4'd6, 1);
    vecs[29] = mk(1,0,0, 0,32'h0,         0,  0,32'h0,          0, 4'd0, 1);

    rst_n = 1'b0; flush_i = 1'b0; flush_half_i = 1'b0;
    push_valid_i = 1'b0; push_data_i = 32'h0; instr_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_push_ready", 32'(push_ready_o), 32'd1);
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_comp", 32'(instr_compressed_o), 32'd0);

    for (int i = 0; i < 30; i++) begin
      rst_n         = vecs[i].rstn;
      flush_i       = vecs[i].fl;
      flush_half_i  = vecs[i].fh;
      push_valid_i  = vecs[i].pv;
      push_data_i   = vecs[i].pd;
      instr_ready_i = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d_valid", i), 32'(instr_valid_o), 32'(vecs[i].ev));
      chk($sformatf("v%0d_instr", i), instr_o, vecs[i].ei);
      chk($sformatf("v%0d_comp", i), 32'(instr_compressed_o), 32'(vecs[i].ec));
      chk($sformatf("v%0d_count", i), 32'(count_o), 32'(vecs[i].ecnt));
      chk($sformatf("v%0d_push_ready", i), 32'(push_ready_o), 32'(vecs[i].epr));
      @(posedge clk);
      @(negedge clk);
    end

    // Random mixed stream; first instruction 32-bit so the fill/pop sequence frees one word.
    mcnt = 0;
    l = 16'(($urandom() & 32'hFFFC) | 32'h3);
    h = 16'($urandom());
    src_hw.push_back(l); src_hw.push_back(h);
    exp_q.push_back('{instr: {h, l}, comp: 1'b0});
    while (src_hw.size() < 120) begin
      if ($urandom_range(0, 1) == 1) begin
        h = 16'(($urandom() & 32'hFFFC) | 32'($urandom_range(0, 2)));
        src_hw.push_back(h);
        exp_q.push_back('{instr: {16'h0, h}, comp: 1'b1});
      end else begin
        l = 16'(($urandom() & 32'hFFFC) | 32'h3);
        h = 16'($urandom());
        src_hw.push_back(l); src_hw.push_back(h);
        exp_q.push_back('{instr: {h, l}, comp: 1'b0});
      end
    end
    if (src_hw.size() % 2 == 1) begin
      src_hw.push_back(16'h0001);
      exp_q.push_back('{instr: 32'h0000_0001, comp: 1'b1});
    end

    repeat (5) step(1'b1, 1'b0);
    chk("full_count", 32'(count_o), 32'd8);
    chk("full_push_ready", 32'(push_ready_o), 32'd0);
    step(1'b0, 1'b1);
    chk("after_pop_push_ready", 32'(push_ready_o), 32'd1);
    step(1'b0, 1'b0);

    cyc = 0;
    while (exp_q.size() > 0 && cyc < 3000) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      cyc++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d instructions left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
